// File: rtl/pixel_frame_collector.sv
// pixel_frame_collector: packs NUM_PIX serial pixel words into one frame word.
// Optional running-XOR output frame_xsum is built when FRAME_CHECKSUM_EN is defined.
module pixel_frame_collector #(
   parameter int DATA_W  = 32,
   parameter int NUM_PIX = 9,
   parameter int CNT_W   = 7
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         pixel_in,
   input  logic                      pixel_valid,
   output logic                      pixel_ready,
   input  logic                      frame_abort,
   output logic [NUM_PIX*DATA_W-1:0] frame_out,
   output logic                      frame_valid,
   input  logic                      frame_ready,
   output logic [CNT_W-1:0]          pixel_count,
   output logic                      overrun_err
`ifdef FRAME_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]         frame_xsum
`endif
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic [NUM_PIX*DATA_W-1:0]   frame_q;
   logic                        overrun_q, overrun_d;
   logic                        accept;
   logic                        last;

   // a pixel is taken only while collecting; abort drops it
   assign accept = (state_q == COLLECT) && pixel_valid && !frame_abort;
   assign last   = (count_q == CNT_W'(NUM_PIX - 1));

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= COLLECT;
      else       state_q <= state_d;
   end

   // next-state: fill to HOLD, leave HOLD on consumer handshake
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT: if (accept && last) state_d = HOLD;
         HOLD:    if (frame_ready)    state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // handshake outputs follow the registered state directly
   always_comb begin
      pixel_ready = (state_q == COLLECT);
      frame_valid = (state_q == HOLD);
   end

   // pixel counter and sticky overrun next-state
   always_comb begin
      count_d   = count_q;
      overrun_d = overrun_q | ((state_q == HOLD) && pixel_valid);
      if (state_q == COLLECT) begin
         if (frame_abort)  count_d = '0;
         else if (accept)  count_d = last ? '0 : count_q + 1'b1;
      end
   end

   // counter and error flag registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // slot storage: only the addressed slot is written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= '0;
      end else if (accept) begin
         for (int k = 0; k < NUM_PIX; k++) begin
            if (count_q == CNT_W'(k)) frame_q[k*DATA_W +: DATA_W] <= pixel_in;
         end
      end
   end

`ifdef FRAME_CHECKSUM_EN
   logic [DATA_W-1:0] xsum_q, xsum_d;

   // running XOR, restarted by abort and by frame handoff
   always_comb begin
      xsum_d = xsum_q;
      if (state_q == COLLECT) begin
         if (frame_abort) xsum_d = '0;
         else if (accept) xsum_d = xsum_q ^ pixel_in;
      end else if (frame_ready) begin
         xsum_d = '0;
      end
   end

   // checksum register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) xsum_q <= '0;
      else       xsum_q <= xsum_d;
   end

   assign frame_xsum = xsum_q;
`endif

   assign frame_out   = frame_q;
   assign pixel_count = count_q;
   assign overrun_err = overrun_q;

endmodule

// File: tb/tb_pixel_frame_collector.sv
// tb_pixel_frame_collector: scoreboard bench for pixel_frame_collector.
// Define FRAME_CHECKSUM_EN to also exercise frame_xsum.
module tb_pixel_frame_collector;

   localparam int DW = 32;
   localparam int NP = 9;
   localparam int CW = 7;
   localparam int FW = NP * DW;

   typedef struct {
      logic [FW-1:0] frame;
      logic [DW-1:0] xsum;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] pixel_in;
   logic          pixel_valid;
   logic          pixel_ready;
   logic          frame_abort;
   logic [FW-1:0] frame_out;
   logic          frame_valid;
   logic          frame_ready;
   logic [CW-1:0] pixel_count;
   logic          overrun_err;
`ifdef FRAME_CHECKSUM_EN
   logic [DW-1:0] frame_xsum;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t expq[$];
   logic [DW-1:0] pix [NP];
   logic [FW-1:0] bp_frame;

   pixel_frame_collector #(.DATA_W(DW), .NUM_PIX(NP), .CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .pixel_in    (pixel_in),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .frame_abort (frame_abort),
      .frame_out   (frame_out),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .pixel_count (pixel_count),
      .overrun_err (overrun_err)
`ifdef FRAME_CHECKSUM_EN
      ,
      .frame_xsum  (frame_xsum)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [FW-1:0] act,
                      input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t build();
      exp_t e;
      e.frame = '0;
      e.xsum  = '0;
      for (int k = 0; k < NP; k++) begin
         e.frame[k*DW +: DW] = pix[k];
         e.xsum = e.xsum ^ pix[k];
      end
      return e;
   endfunction

   task automatic send(input logic [DW-1:0] d);
      pixel_in    = d;
      pixel_valid = 1'b1;
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
   endtask

   task automatic send_frame();
      expq.push_back(build());
      for (int k = 0; k < NP; k++) send(pix[k]);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (frame_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (frame_valid) begin
         checks++;
         errors++;
         $display("FAIL %s timeout frame_valid still 1 expected 0", name);
      end
   endtask

   // monitor: every handshake pops one expected frame
   always @(negedge clk) begin
      if (!reset && frame_valid && frame_ready) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame got %0h expected none", frame_out);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("frame_out", frame_out, e.frame);
`ifdef FRAME_CHECKSUM_EN
            chk("frame_xsum", FW'(frame_xsum), FW'(e.xsum));
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      pixel_in    = '0;
      pixel_valid = 1'b0;
      frame_abort = 1'b0;
      frame_ready = 1'b1;
      #12;
      chk("rst_count", FW'(pixel_count), FW'(0));
      chk("rst_valid", FW'(frame_valid), FW'(0));
      chk("rst_ready", FW'(pixel_ready), FW'(1));
      chk("rst_overrun", FW'(overrun_err), FW'(0));
      chk("rst_frame", frame_out, '0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // basic fill
      for (int k = 0; k < NP; k++) pix[k] = 32'h3f00_0000 + 32'(k) * 32'h0010_0000;
      send_frame();
      chk("lat_valid", FW'(frame_valid), FW'(1));
      chk("lat_ready", FW'(pixel_ready), FW'(0));
      chk("slot0", FW'(frame_out[31:0]), FW'(32'h3f00_0000));
      chk("slot8", FW'(frame_out[287:256]), FW'(32'h3f80_0000));
      @(posedge clk);
      #1;
      chk("basic_valid_low", FW'(frame_valid), FW'(0));
      chk("basic_count", FW'(pixel_count), FW'(0));

      // back-pressure with overrun attempts
      frame_ready = 1'b0;
      for (int k = 0; k < NP; k++) pix[k] = 32'h1000_0000 + 32'(k);
      bp_frame = build().frame;
      send_frame();
      for (int c = 0; c < 5; c++) begin
         pixel_in    = 32'h3f70_0000;
         pixel_valid = 1'b1;
         chk("bp_ready", FW'(pixel_ready), FW'(0));
         chk("bp_valid", FW'(frame_valid), FW'(1));
         chk("bp_stable", frame_out, bp_frame);
         @(posedge clk);
         #1;
      end
      pixel_valid = 1'b0;
      chk("bp_overrun", FW'(overrun_err), FW'(1));
      chk("bp_after", frame_out, bp_frame);
      chk("bp_count", FW'(pixel_count), FW'(0));
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_released", FW'(frame_valid), FW'(0));
      send(32'haaaa_5555);
      chk("next_count", FW'(pixel_count), FW'(1));
      chk("next_slot0", FW'(frame_out[31:0]), FW'(32'haaaa_5555));
      frame_abort = 1'b1;
      @(posedge clk);
      #1;
      frame_abort = 1'b0;
      chk("clr_count", FW'(pixel_count), FW'(0));

      // gapped input
      for (int k = 0; k < NP; k++) pix[k] = 32'h3f00_0000 + 32'(k) * 32'h0010_0000;
      expq.push_back(build());
      for (int k = 0; k < NP; k++) begin
         send(pix[k]);
         if (k < NP - 1) begin
            chk("gap_count_v", FW'(pixel_count), FW'(k + 1));
            pixel_in = 32'hdead_beef;
            @(posedge clk);
            #1;
            chk("gap_count_i", FW'(pixel_count), FW'(k + 1));
         end
      end
      chk("gap_valid", FW'(frame_valid), FW'(1));
      wait_idle("gap_idle");

      // abort with a simultaneous pixel
      for (int k = 0; k < 4; k++) send(32'h2000_0000 + 32'(k));
      chk("ab_pre", FW'(pixel_count), FW'(4));
      pixel_in    = 32'h1234_5678;
      pixel_valid = 1'b1;
      frame_abort = 1'b1;
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      frame_abort = 1'b0;
      chk("ab_count", FW'(pixel_count), FW'(0));
      for (int k = 0; k < NP; k++) pix[k] = 32'h3f70_0000;
      send_frame();
      wait_idle("ab_idle");

      // async reset mid-frame
      for (int k = 0; k < 5; k++) send(32'h3000_0000 + 32'(k));
      #2;
      reset = 1'b1;
      #1;
      chk("ar_count", FW'(pixel_count), FW'(0));
      chk("ar_valid", FW'(frame_valid), FW'(0));
      chk("ar_ready", FW'(pixel_ready), FW'(1));
      chk("ar_overrun", FW'(overrun_err), FW'(0));
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < NP; k++) pix[k] = 32'h4000_0000 + 32'(k) * 32'h11;
      send_frame();
      wait_idle("ar_idle");

`ifdef FRAME_CHECKSUM_EN
      frame_ready = 1'b0;
      for (int k = 0; k < NP; k++) pix[k] = 32'(k + 1);
      send_frame();
      chk("xsum_hold", FW'(frame_xsum), FW'(32'h1));
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("xsum_clear", FW'(frame_xsum), FW'(0));
`endif

      @(posedge clk);
      #1;
      chk("frames_drained", FW'(expq.size()), FW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
